// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding and load-use detection
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_alu_sel,
    input  logic            id_is_signed,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            stall,
    input  logic            flush,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [3:0]      ex_alu_sel,
    output logic            ex_is_signed,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_valid,
    output logic            load_use_hazard
);

    logic            valid_q,     valid_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [RA_W-1:0] rs1_q,       rs1_d;
    logic [RA_W-1:0] rs2_q,       rs2_d;
    logic [RA_W-1:0] rd_q,        rd_d;
    logic [3:0]      alu_sel_q,   alu_sel_d;
    logic            is_signed_q, is_signed_d;
    logic            use_imm_q,   use_imm_d;
    logic            use_pc_q,    use_pc_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q,  mem_read_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            wb_hits_rs1;
    logic            wb_hits_rs2;

    // A load sitting in EX cannot forward in time to an ID consumer; rs2 is
    // compared even when ID does not read it, trading a rare extra stall for
    // not needing per-opcode operand usage here.
    always_comb begin
        load_use_hazard = id_valid & valid_q & mem_read_q & (rd_q != '0) &
                          ((rd_q == id_rs1) | (rd_q == id_rs2));
    end

    // WB write that targets a held source; used to refresh the held operand
    // so the value is not lost once WB retires while EX is stalled.
    always_comb begin
        wb_hits_rs1 = wb_reg_write & (wb_rd != '0) & (wb_rd == rs1_q);
        wb_hits_rs2 = wb_reg_write & (wb_rd != '0) & (wb_rd == rs2_q);
    end

    // Next-state selection: flush beats stall, stall beats the load-use bubble.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        alu_sel_d   = alu_sel_q;
        is_signed_d = is_signed_q;
        use_imm_d   = use_imm_q;
        use_pc_d    = use_pc_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (stall) begin
            if (wb_hits_rs1) begin
                rs1_data_d = wb_result;
            end
            if (wb_hits_rs2) begin
                rs2_data_d = wb_result;
            end
        end else if (load_use_hazard) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            alu_sel_d   = id_alu_sel;
            is_signed_d = id_is_signed;
            use_imm_d   = id_use_imm;
            use_pc_d    = id_use_pc;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
        end
    end

    // Pipeline register; reset leaves the stage empty with all fields cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_sel_q   <= 4'b0000;
            is_signed_q <= 1'b0;
            use_imm_q   <= 1'b0;
            use_pc_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_sel_q   <= alu_sel_d;
            is_signed_q <= is_signed_d;
            use_imm_q   <= use_imm_d;
            use_pc_q    <= use_pc_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // rs1 forwarding: x0 never forwards, the younger MEM result beats WB.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_q != '0) begin
            if (mem_reg_write && (mem_rd == rs1_q)) begin
                fwd_rs1 = mem_result;
            end else if (wb_reg_write && (wb_rd == rs1_q)) begin
                fwd_rs1 = wb_result;
            end
        end
    end

    // rs2 forwarding, same priority as rs1.
    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (rs2_q != '0) begin
            if (mem_reg_write && (mem_rd == rs2_q)) begin
                fwd_rs2 = mem_result;
            end else if (wb_reg_write && (wb_rd == rs2_q)) begin
                fwd_rs2 = wb_result;
            end
        end
    end

    // Operand select and ALU-facing outputs; side effects only for real instructions.
    always_comb begin
        ex_op1        = use_pc_q  ? pc_q  : fwd_rs1;
        ex_op2        = use_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
        ex_alu_sel    = alu_sel_q;
        ex_is_signed  = is_signed_q;
        ex_rd         = rd_q;
        ex_valid      = valid_q;
        ex_reg_write  = valid_q & reg_write_q;
        ex_mem_read   = valid_q & mem_read_q;
    end

endmodule
